// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: bus stores fill a small byte FIFO
// that a baud-timed serializer drains onto the tx line.
module uart_tx_mmio #(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [31:0] TX_ADDR      = 32'h0000_0400,
    parameter logic [31:0] STAT_ADDR    = 32'h0000_0404
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = PW + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [NW-1:0] DEPTH_N  = NW'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [7:0]    fifo_mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [NW-1:0] count_r;
    logic          overflow_r;
    logic [1:0]    state_r;
    logic [CW-1:0] cyc_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    shift_r;
    logic          tx_r;

    logic          fifo_empty_s;
    logic          fifo_full_s;
    logic          bit_end_s;
    logic          push_req_s;
    logic          push_ok_s;
    logic          drop_s;
    logic          ovf_clr_s;
    logic          pop_s;
    logic [7:0]    head_s;
    logic          unused_s;

    assign fifo_empty_s = (count_r == {NW{1'b0}});
    assign fifo_full_s  = (count_r == DEPTH_N);
    assign bit_end_s    = (cyc_r == CNT_LAST);
    assign push_req_s   = we && (addr == TX_ADDR);
    assign ovf_clr_s    = we && (addr == STAT_ADDR) && wdata[3];
    assign push_ok_s    = push_req_s && (!fifo_full_s || pop_s);
    assign drop_s       = push_req_s && fifo_full_s && !pop_s;
    assign head_s       = fifo_mem_r[rd_ptr_r];
    assign unused_s     = ^wdata[31:8];

    // The serializer takes the FIFO head when idle or at the very end of a stop bit.
    always_comb begin
        pop_s = 1'b0;
        case (state_r)
            ST_IDLE: pop_s = !fifo_empty_s;
            ST_STOP: pop_s = bit_end_s && !fifo_empty_s;
            default: pop_s = 1'b0;
        endcase
    end

    // Status register read mux.
    always_comb begin
        rdata = 32'h0000_0000;
        if (addr == STAT_ADDR) begin
            rdata = {28'h000_0000, overflow_r, fifo_empty_s, fifo_full_s,
                     (state_r != ST_IDLE)};
        end else begin
            rdata = 32'h0000_0000;
        end
    end

    // FIFO storage; data words carry no reset value.
    always_ff @(posedge clk) begin
        if (!reset && push_ok_s) begin
            fifo_mem_r[wr_ptr_r] <= wdata[7:0];
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            count_r    <= {NW{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            end
            count_r <= count_r + NW'(push_ok_s) - NW'(pop_s);
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (ovf_clr_s) begin
                overflow_r <= 1'b0;
            end
        end
    end

    // Frame serializer; tx is registered so the bus never reaches the line combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cyc_r     <= {CW{1'b0}};
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            tx_r      <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cyc_r <= {CW{1'b0}};
                    if (pop_s) begin
                        shift_r <= head_s;
                        state_r <= ST_START;
                        tx_r    <= 1'b0;
                    end else begin
                        tx_r    <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        cyc_r     <= {CW{1'b0}};
                        bit_idx_r <= 3'd0;
                        state_r   <= ST_DATA;
                        tx_r      <= shift_r[0];
                    end else begin
                        cyc_r <= cyc_r + CW'(1'b1);
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        cyc_r   <= {CW{1'b0}};
                        shift_r <= {1'b0, shift_r[7:1]};
                        if (bit_idx_r == 3'd7) begin
                            state_r <= ST_STOP;
                            tx_r    <= 1'b1;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            tx_r      <= shift_r[1];
                        end
                    end else begin
                        cyc_r <= cyc_r + CW'(1'b1);
                    end
                end
                ST_STOP: begin
                    if (bit_end_s) begin
                        cyc_r <= {CW{1'b0}};
                        if (pop_s) begin
                            shift_r <= head_s;
                            state_r <= ST_START;
                            tx_r    <= 1'b0;
                        end else begin
                            state_r <= ST_IDLE;
                            tx_r    <= 1'b1;
                        end
                    end else begin
                        cyc_r <= cyc_r + CW'(1'b1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cyc_r   <= {CW{1'b0}};
                    tx_r    <= 1'b1;
                end
            endcase
        end
    end

    assign tx   = tx_r;
    assign busy = (state_r != ST_IDLE) || !fifo_empty_s;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: a queue-based line model checks every cycle,
// and hand-computed literals pin the key scenarios.
module tb_uart_tx_mmio;

    localparam int          CPB       = 4;
    localparam int          DEPTH     = 4;
    localparam logic [31:0] TX_ADDR   = 32'h0000_0400;
    localparam logic [31:0] STAT_ADDR = 32'h0000_0404;

    logic        clk;
    logic        reset;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        tx;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    uart_tx_mmio #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .TX_ADDR     (TX_ADDR),
        .STAT_ADDR   (STAT_ADDR)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .we   (we),
        .addr (addr),
        .wdata(wdata),
        .rdata(rdata),
        .tx   (tx),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: pending bytes plus the per-cycle line values of the frame in flight.
    logic [7:0] mq[$];
    bit         line[$];
    bit         m_ovf = 1'b0;
    bit         armed = 1'b0;

    always begin
        logic [7:0]  b;
        bit          v;
        logic [31:0] exp_rd;
        @(posedge clk);
        #1;
        cyc++;
        if (reset) begin
            mq.delete();
            line.delete();
            m_ovf = 1'b0;
            armed = 1'b1;
        end else if (armed) begin
            if (line.size() > 0) void'(line.pop_front());
            if (line.size() == 0 && mq.size() > 0) begin
                b = mq.pop_front();
                for (int k = 0; k < 10; k++) begin
                    v = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
                    for (int j = 0; j < CPB; j++) line.push_back(v);
                end
            end
            if (we && addr == TX_ADDR) begin
                if (mq.size() < DEPTH) mq.push_back(wdata[7:0]);
                else m_ovf = 1'b1;
            end
            if (we && addr == STAT_ADDR && wdata[3]) m_ovf = 1'b0;
        end
        if (armed) begin
            exp_rd = (addr == STAT_ADDR) ?
                     {28'h000_0000, m_ovf, (mq.size() == 0), (mq.size() == DEPTH), (line.size() != 0)} :
                     32'h0000_0000;
            check("model_tx",    {31'h0, tx},   {31'h0, (line.size() == 0) ? 1'b1 : line[0]});
            check("model_busy",  {31'h0, busy}, {31'h0, (line.size() != 0) || (mq.size() != 0)});
            check("model_rdata", rdata, exp_rd);
        end
    end

    task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        we    = w;
        addr  = a;
        wdata = d;
    endtask

    bit exp_a5 [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        reset = 1'b1;
        we    = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Idle after reset
        step(1'b0, STAT_ADDR, 32'h0);
        repeat (50) @(negedge clk);
        @(posedge clk); #1;
        check("idle_tx",   {31'h0, tx},   32'h1);
        check("idle_busy", {31'h0, busy}, 32'h0);
        check("idle_stat", rdata, 32'h0000_0004);

        // Single byte 0xA5: start low one clock after the write edge, 4 cycles per bit
        step(1'b1, TX_ADDR, 32'h0000_00A5);
        step(1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            check($sformatf("a5_bit%0d", i / CPB), {31'h0, tx}, {31'h0, exp_a5[i / CPB]});
        end
        check("a5_busy_stop", {31'h0, busy}, 32'h1);
        @(posedge clk); #1;
        check("a5_busy_done", {31'h0, busy}, 32'h0);
        check("a5_tx_idle",   {31'h0, tx},   32'h1);

        // Six back-to-back writes into a depth-4 FIFO
        for (int i = 0; i < 6; i++) step(1'b1, TX_ADDR, 32'h11 + i);
        step(1'b0, STAT_ADDR, 32'h0);
        @(posedge clk); #1;
        check("ovf_stat", rdata, 32'h0000_000B);
        step(1'b1, STAT_ADDR, 32'h0000_0008);
        step(1'b0, STAT_ADDR, 32'h0);
        @(posedge clk); #1;
        check("ovf_clr_stat", rdata, 32'h0000_0003);
        repeat (230) @(negedge clk);
        @(posedge clk); #1;
        check("drain_busy", {31'h0, busy}, 32'h0);
        check("drain_stat", rdata, 32'h0000_0004);

        // Write to an unmapped address
        step(1'b1, 32'h0000_0408, 32'h0000_0055);
        step(1'b0, 32'h0000_0408, 32'h0);
        @(posedge clk); #1;
        check("bad_rdata", rdata, 32'h0);
        check("bad_tx",    {31'h0, tx},   32'h1);
        check("bad_busy",  {31'h0, busy}, 32'h0);
        repeat (10) @(negedge clk);
        @(posedge clk); #1;
        check("bad_tx_later", {31'h0, tx}, 32'h1);

        // Reset in the middle of data bit 3 with two bytes still queued
        step(1'b1, TX_ADDR, 32'h0000_00C3);
        step(1'b1, TX_ADDR, 32'h0000_003C);
        step(1'b1, TX_ADDR, 32'h0000_005A);
        step(1'b0, STAT_ADDR, 32'h0);
        repeat (15) @(negedge clk);
        check("pre_reset_busy", {31'h0, busy}, 32'h1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_tx",   {31'h0, tx},   32'h1);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_stat", rdata, 32'h0000_0004);
        @(negedge clk);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        @(posedge clk); #1;
        check("post_rst_tx",   {31'h0, tx}, 32'h1);
        check("post_rst_stat", rdata, 32'h0000_0004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
